// File: rtl/uart_cmd_link.sv
// uart_cmd_link: 8N1 host link that assembles 3 received bytes into a 24-bit command and transmits response bytes.
//   BAUD_DIV     clocks per bit period (8..4095)
//   clk, rst_n   system clock, asynchronous active-low reset
//   RX, TX       serial lines to/from host, both idle high
//   cmd          assembled command, first byte in [23:16]
//   cmd_rdy      level, cmd valid and stable while high
//   clr_cmd_rdy  one-clock pulse from core that clears cmd_rdy
//   resp_data    response byte, latched when send_resp is seen while TX is idle
//   send_resp    one-clock pulse starting a response frame
//   resp_sent    one-clock pulse when the response stop bit completes
//   frm_err      one-clock pulse on a received byte with a bad stop bit
//   ovr_err      one-clock pulse when a complete byte is dropped because cmd_rdy is high
module uart_cmd_link #(
    parameter int BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        frm_err,
    output logic        ovr_err
);
    localparam logic [12:0] BIT_T  = 13'(BAUD_DIV);
    localparam logic [12:0] HALF_T = 13'(BAUD_DIV / 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      rx_st, tx_st;
    logic        rx_m, rx_s, rx_q;
    logic [12:0] rx_cnt, tx_cnt;
    logic [2:0]  rx_bit, tx_bit;
    logic [7:0]  rx_sh, tx_sh;
    logic [1:0]  bcnt;
    logic [15:0] stg;
    logic        rx_exp, tx_exp;

    assign rx_exp = (rx_cnt == 13'd1);
    assign tx_exp = (tx_cnt == 13'd1);

    // rx_q holds the previous synchronized value for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {rx_m, rx_s, rx_q} <= 3'b111;
        else        {rx_m, rx_s, rx_q} <= {RX, rx_m, rx_s};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st   <= IDLE;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
            bcnt    <= '0;
            stg     <= '0;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
            // a third byte landing in the same cycle overrides this clear below
            if (clr_cmd_rdy) cmd_rdy <= 1'b0;
            if (rx_st != IDLE && !rx_exp) rx_cnt <= rx_cnt - 13'd1;
            case (rx_st)
                IDLE: if (rx_q && !rx_s) begin
                    rx_cnt <= HALF_T;
                    rx_st  <= START;
                end
                START: if (rx_exp) begin
                    rx_cnt <= BIT_T;
                    rx_bit <= '0;
                    rx_st  <= rx_s ? IDLE : DATA;
                end
                DATA: if (rx_exp) begin
                    rx_sh  <= {rx_s, rx_sh[7:1]};
                    rx_cnt <= BIT_T;
                    rx_bit <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_st <= STOP;
                end
                STOP: if (rx_exp) begin
                    rx_st <= IDLE;
                    if (!rx_s) begin
                        frm_err <= 1'b1;
                        bcnt    <= '0;
                    end else if (cmd_rdy && !clr_cmd_rdy) begin
                        ovr_err <= 1'b1;
                    end else if (bcnt == 2'd2) begin
                        // first two bytes wait in stg so cmd only moves as a whole word
                        cmd     <= {stg, rx_sh};
                        cmd_rdy <= 1'b1;
                        bcnt    <= '0;
                    end else begin
                        stg  <= (bcnt == 2'd0) ? {rx_sh, stg[7:0]} : {stg[15:8], rx_sh};
                        bcnt <= bcnt + 2'd1;
                    end
                end
                default: rx_st <= IDLE;
            endcase
        end
    end

    // START is entered one clock before the start bit goes out (BIT_T+1 load) and
    // STOP is left one clock early (BIT_T-1 load), so the idle cycle carrying
    // resp_sent can accept the next send_resp for back-to-back frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st     <= IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= '0;
            TX        <= 1'b1;
            resp_sent <= 1'b0;
        end else begin
            resp_sent <= 1'b0;
            if (tx_st != IDLE && !tx_exp) tx_cnt <= tx_cnt - 13'd1;
            case (tx_st)
                IDLE: if (send_resp) begin
                    tx_sh  <= resp_data;
                    tx_cnt <= BIT_T + 13'd1;
                    tx_st  <= START;
                end
                START: begin
                    TX <= 1'b0;
                    if (tx_exp) begin
                        TX     <= tx_sh[0];
                        tx_sh  <= tx_sh >> 1;
                        tx_bit <= '0;
                        tx_cnt <= BIT_T;
                        tx_st  <= DATA;
                    end
                end
                DATA: if (tx_exp) begin
                    if (tx_bit == 3'd7) begin
                        TX     <= 1'b1;
                        tx_cnt <= BIT_T - 13'd1;
                        tx_st  <= STOP;
                    end else begin
                        TX     <= tx_sh[0];
                        tx_sh  <= tx_sh >> 1;
                        tx_bit <= tx_bit + 3'd1;
                        tx_cnt <= BIT_T;
                    end
                end
                STOP: if (tx_exp) begin
                    tx_st     <= IDLE;
                    resp_sent <= 1'b1;
                end
                default: tx_st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_link.sv
// tb_uart_cmd_link: randomized self-checking bench for uart_cmd_link against a byte-level command model.
module tb_uart_cmd_link;
    localparam int B = 8;

    logic        clk = 1'b0, rst_n = 1'b0, rx = 1'b1, clr = 1'b0, send = 1'b0;
    logic [7:0]  rdata = 8'h00;
    logic        tx, cmd_rdy, resp_sent, frm_err, ovr_err;
    logic [23:0] cmd;

    int n_checks = 0, n_errors = 0;
    int n_frm = 0, n_ovr = 0, n_sent = 0;
    int exp_frm = 0, exp_ovr = 0;
    logic [7:0]  m_bytes [3];
    int          m_idx = 0;
    logic        m_rdy = 1'b0;
    logic [23:0] m_cmd = 24'h0;

    uart_cmd_link #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst_n(rst_n), .RX(rx), .TX(tx), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr), .resp_data(rdata), .send_resp(send), .resp_sent(resp_sent),
        .frm_err(frm_err), .ovr_err(ovr_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frm_err) n_frm++;
        if (ovr_err) n_ovr++;
        if (resp_sent) n_sent++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Host frame: start, 8 data LSB first, stop; clr pulses during the clock whose
    // negedge index equals clr_at (78 lands on the stop-sample edge).
    task automatic send_byte(input logic [7:0] b, input logic stop, input int clr_at);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10 * B; i++) begin
            @(negedge clk);
            rx  = fr[i / B];
            clr = (i == clr_at);
        end
        @(negedge clk);
        rx  = 1'b1;
        clr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic model_rx(input logic [7:0] b, input logic good, input logic clr_same);
        logic r0;
        r0 = m_rdy;
        if (clr_same) m_rdy = 1'b0;
        if (!good) begin
            m_idx = 0;
            exp_frm++;
        end else if (r0 && !clr_same) begin
            exp_ovr++;
        end else if (m_idx == 2) begin
            m_cmd = {m_bytes[0], m_bytes[1], b};
            m_rdy = 1'b1;
            m_idx = 0;
        end else begin
            m_bytes[m_idx] = b;
            m_idx++;
        end
    endtask

    task automatic pulse_clr;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_rdy = 1'b0;
    endtask

    task automatic test_reset;
        n_checks += 6;
        if (tx !== 1'b1) begin n_errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        if (cmd !== 24'h0) begin n_errors++; $display("FAIL reset_cmd: got %h expected 000000", cmd); end
        if (cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); end
        if (resp_sent !== 1'b0) begin n_errors++; $display("FAIL reset_resp_sent: got %b expected 0", resp_sent); end
        if (frm_err !== 1'b0) begin n_errors++; $display("FAIL reset_frm_err: got %b expected 0", frm_err); end
        if (ovr_err !== 1'b0) begin n_errors++; $display("FAIL reset_ovr_err: got %b expected 0", ovr_err); end
    endtask

    task automatic test_cmd;
        send_byte(8'h05, 1'b1, -1); model_rx(8'h05, 1'b1, 1'b0);
        send_byte(8'hA3, 1'b1, -1); model_rx(8'hA3, 1'b1, 1'b0);
        n_checks += 2;
        if (cmd !== 24'h0) begin n_errors++; $display("FAIL cmd_partial: got %h expected 000000", cmd); end
        if (cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL cmd_rdy_partial: got %b expected 0", cmd_rdy); end
        send_byte(8'h7F, 1'b1, -1); model_rx(8'h7F, 1'b1, 1'b0);
        n_checks += 3;
        if (cmd !== 24'h05A37F) begin n_errors++; $display("FAIL cmd_word: got %h expected 05a37f", cmd); end
        if (cmd !== m_cmd) begin n_errors++; $display("FAIL cmd_model: got %h expected %h", cmd, m_cmd); end
        if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL cmd_rdy_set: got %b expected 1", cmd_rdy); end
        repeat (20) @(negedge clk);
        n_checks++;
        if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL cmd_rdy_hold: got %b expected 1", cmd_rdy); end
        pulse_clr;
        n_checks++;
        if (cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL cmd_rdy_clear: got %b expected 0", cmd_rdy); end
    endtask

    task automatic test_tx;
        logic [9:0] fr;
        logic       e;
        int         s0;
        fr = {1'b1, 8'hA5, 1'b0};
        s0 = n_sent;
        @(negedge clk);
        rdata = 8'hA5;
        send  = 1'b1;
        for (int i = 1; i <= 90; i++) begin
            @(negedge clk);
            send = (i == 40);
            if (i == 40) rdata = 8'h3C;
            e = (i >= 2 && i <= 81) ? fr[(i - 2) / B] : 1'b1;
            n_checks += 2;
            if (tx !== e) begin n_errors++; $display("FAIL tx_bit at clock %0d: got %b expected %b", i, tx, e); end
            if (resp_sent !== (i == 81)) begin n_errors++; $display("FAIL tx_resp_sent at clock %0d: got %b expected %b", i, resp_sent, i == 81); end
        end
        n_checks++;
        if (n_sent - s0 != 1) begin n_errors++; $display("FAIL tx_sent_count: got %0d expected 1", n_sent - s0); end
    endtask

    task automatic test_frm_err;
        logic [7:0] b;
        send_byte(8'h5A, 1'b1, -1); model_rx(8'h5A, 1'b1, 1'b0);
        b = 8'($urandom);
        send_byte(b, 1'b0, -1); model_rx(b, 1'b0, 1'b0);
        n_checks += 2;
        if (n_frm !== exp_frm) begin n_errors++; $display("FAIL frm_err_count: got %0d expected %0d", n_frm, exp_frm); end
        if (cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL frm_cmd_rdy: got %b expected 0", cmd_rdy); end
        send_byte(8'h11, 1'b1, -1); model_rx(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, -1); model_rx(8'h22, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, -1); model_rx(8'h33, 1'b1, 1'b0);
        n_checks += 2;
        if (cmd !== 24'h112233) begin n_errors++; $display("FAIL frm_recover_cmd: got %h expected 112233", cmd); end
        if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL frm_recover_rdy: got %b expected 1", cmd_rdy); end
        pulse_clr;
    endtask

    task automatic test_glitch;
        logic [7:0] b;
        @(negedge clk); rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        n_checks += 3;
        if (n_frm !== exp_frm) begin n_errors++; $display("FAIL glitch_frm: got %0d expected %0d", n_frm, exp_frm); end
        if (n_ovr !== exp_ovr) begin n_errors++; $display("FAIL glitch_ovr: got %0d expected %0d", n_ovr, exp_ovr); end
        if (cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL glitch_rdy: got %b expected 0", cmd_rdy); end
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1, -1); model_rx(b, 1'b1, 1'b0);
        end
        n_checks += 2;
        if (cmd !== m_cmd) begin n_errors++; $display("FAIL glitch_cmd: got %h expected %h", cmd, m_cmd); end
        if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL glitch_cmd_rdy: got %b expected 1", cmd_rdy); end
    endtask

    task automatic test_overrun;
        logic [7:0]  b;
        logic [23:0] held;
        held = m_cmd;
        send_byte(8'hEE, 1'b1, -1); model_rx(8'hEE, 1'b1, 1'b0);
        n_checks += 3;
        if (n_ovr !== exp_ovr) begin n_errors++; $display("FAIL ovr_count: got %0d expected %0d", n_ovr, exp_ovr); end
        if (cmd !== held) begin n_errors++; $display("FAIL ovr_cmd_held: got %h expected %h", cmd, held); end
        if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL ovr_rdy: got %b expected 1", cmd_rdy); end
        pulse_clr;
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1, -1); model_rx(b, 1'b1, 1'b0);
        end
        n_checks += 2;
        if (cmd !== m_cmd) begin n_errors++; $display("FAIL ovr_next_cmd: got %h expected %h", cmd, m_cmd); end
        if (n_ovr !== exp_ovr) begin n_errors++; $display("FAIL ovr_next_count: got %0d expected %0d", n_ovr, exp_ovr); end
    endtask

    task automatic test_simul_clr;
        logic [7:0] x, y, z;
        x = 8'($urandom); y = 8'($urandom); z = 8'($urandom);
        send_byte(x, 1'b1, 78); model_rx(x, 1'b1, 1'b1);
        send_byte(y, 1'b1, -1); model_rx(y, 1'b1, 1'b0);
        send_byte(z, 1'b1, 78); model_rx(z, 1'b1, 1'b1);
        n_checks += 3;
        if (cmd !== {x, y, z}) begin n_errors++; $display("FAIL simul_cmd: got %h expected %h", cmd, {x, y, z}); end
        if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL simul_rdy: got %b expected 1", cmd_rdy); end
        if (n_ovr !== exp_ovr) begin n_errors++; $display("FAIL simul_ovr: got %0d expected %0d", n_ovr, exp_ovr); end
        pulse_clr;
    endtask

    task automatic test_random;
        logic [7:0] b;
        logic       good, cs;
        for (int k = 0; k < 16; k++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            cs   = ($urandom_range(0, 3) == 0);
            send_byte(b, good, cs ? 78 : -1);
            model_rx(b, good, cs);
            n_checks += 4;
            if (cmd !== m_cmd) begin n_errors++; $display("FAIL rand_cmd byte %0d: got %h expected %h", k, cmd, m_cmd); end
            if (cmd_rdy !== m_rdy) begin n_errors++; $display("FAIL rand_rdy byte %0d: got %b expected %b", k, cmd_rdy, m_rdy); end
            if (n_frm !== exp_frm) begin n_errors++; $display("FAIL rand_frm byte %0d: got %0d expected %0d", k, n_frm, exp_frm); end
            if (n_ovr !== exp_ovr) begin n_errors++; $display("FAIL rand_ovr byte %0d: got %0d expected %0d", k, n_ovr, exp_ovr); end
            if ($urandom_range(0, 2) == 0) pulse_clr;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d1, d2;
        logic [9:0] f1, f2;
        logic       e;
        int         s0;
        d1 = 8'($urandom); d2 = 8'($urandom);
        f1 = {1'b1, d1, 1'b0}; f2 = {1'b1, d2, 1'b0};
        s0 = n_sent;
        @(negedge clk);
        rdata = d1;
        send  = 1'b1;
        for (int i = 1; i <= 170; i++) begin
            @(negedge clk);
            send = (i == 81);
            if (i == 81) rdata = d2;
            e = (i >= 2 && i <= 81) ? f1[(i - 2) / B] : (i >= 83 && i <= 162) ? f2[(i - 83) / B] : 1'b1;
            n_checks += 2;
            if (tx !== e) begin n_errors++; $display("FAIL b2b_tx at clock %0d: got %b expected %b", i, tx, e); end
            if (resp_sent !== (i == 81 || i == 162)) begin n_errors++; $display("FAIL b2b_resp_sent at clock %0d: got %b", i, resp_sent); end
        end
        n_checks++;
        if (n_sent - s0 != 2) begin n_errors++; $display("FAIL b2b_sent_count: got %0d expected 2", n_sent - s0); end
    endtask

    task automatic test_reset_mid;
        logic [9:0] fr;
        logic [7:0] b;
        if (m_rdy) pulse_clr;
        send_byte(8'h9C, 1'b1, -1); model_rx(8'h9C, 1'b1, 1'b0);
        fr = {1'b1, 8'h0F, 1'b0};
        @(negedge clk);
        rdata = 8'h00;
        send  = 1'b1;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            send = 1'b0;
            rx   = fr[i / B];
        end
        rst_n = 1'b0;
        #1;
        m_idx = 0; m_rdy = 1'b0; m_cmd = 24'h0;
        n_checks += 3;
        if (tx !== 1'b1) begin n_errors++; $display("FAIL midrst_tx: got %b expected 1", tx); end
        if (cmd !== 24'h0) begin n_errors++; $display("FAIL midrst_cmd: got %h expected 000000", cmd); end
        if (cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL midrst_rdy: got %b expected 0", cmd_rdy); end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1, -1); model_rx(b, 1'b1, 1'b0);
        end
        n_checks += 3;
        if (cmd !== m_cmd) begin n_errors++; $display("FAIL midrst_cmd_after: got %h expected %h", cmd, m_cmd); end
        if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL midrst_rdy_after: got %b expected 1", cmd_rdy); end
        if (n_frm !== exp_frm) begin n_errors++; $display("FAIL midrst_frm: got %0d expected %0d", n_frm, exp_frm); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_reset;
        test_cmd;
        test_tx;
        test_frm_err;
        test_glitch;
        test_overrun;
        test_simul_clr;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
